// File: rtl/level_pkg.sv
// Shared types for the level sequencer: FSM state encoding and the counter-width helper.
package level_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        LEVEL_UP = 2'b01,
        HOLD     = 2'b10,
        RELOAD   = 2'b11
    } state_t;

    // Wide enough to hold the larger of the two phase lengths without wrapping.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/level_hold_timer.sv
// Loadable up-counter shared by the HOLD and RELOAD phases; done fires on the last counted cycle.
module level_hold_timer #(
    parameter int CNT_W = 4
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             clr,
    input  logic             start,
    input  logic             pause,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] cnt;
    logic             active;

    assign done = active && !pause && (cnt == (limit - CNT_W'(1)));

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (clr) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            // A start coinciding with done re-arms for the next phase.
            cnt    <= '0;
            active <= 1'b1;
        end else if (active && !pause) begin
            if (done) begin
                cnt    <= '0;
                active <= 1'b0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/level_ctrl.sv
// Level sequencer: detects a cleared wave, bumps the level, holds the banner, then requests respawn.
// Build option LEVEL_WRAP_EN: wrap to START_LEVEL at MAX_LEVEL instead of saturating and flagging game_won.
module level_ctrl
    import level_pkg::*;
#(
    parameter int N_ENEMIES     = 5,
    parameter int LEVEL_W       = 4,
    parameter int START_LEVEL   = 1,
    parameter int MAX_LEVEL     = 15,
    parameter int HOLD_CYCLES   = 100000000,
    parameter int RELOAD_CYCLES = 100
) (
    input  logic                 pclk,
    input  logic                 rst,
    input  logic [N_ENEMIES-1:0] lives,
    input  logic                 restart,
    input  logic                 pause,
    output logic [LEVEL_W-1:0]   level,
    output logic                 level_up_out,
    output logic                 level_up_pulse,
    output logic                 respawn,
    output logic                 game_won
);

    localparam int                 CNT_W   = cnt_width(HOLD_CYCLES, RELOAD_CYCLES);
    localparam logic [LEVEL_W-1:0] START_L = LEVEL_W'(START_LEVEL);
    localparam logic [LEVEL_W-1:0] MAX_L   = LEVEL_W'(MAX_LEVEL);

    state_t             state;
    logic               armed;
    logic               tmr_start;
    logic               tmr_done;
    logic [CNT_W-1:0]   tmr_limit;
    logic               at_max;
    logic [LEVEL_W-1:0] next_level;

    assign tmr_limit = (state == RELOAD) ? CNT_W'(RELOAD_CYCLES) : CNT_W'(HOLD_CYCLES);
    assign tmr_start = (state == LEVEL_UP) || ((state == HOLD) && tmr_done);
    assign at_max    = (level >= MAX_L);

`ifdef LEVEL_WRAP_EN
    assign next_level = at_max ? START_L : level + LEVEL_W'(1);
    assign game_won   = 1'b0;
`else
    assign next_level = at_max ? level : level + LEVEL_W'(1);

    always_ff @(posedge pclk or posedge rst) begin
        if (rst)
            game_won <= 1'b0;
        else if (restart)
            game_won <= 1'b0;
        else if ((state == LEVEL_UP) && at_max)
            game_won <= 1'b1;
    end
`endif

    level_hold_timer #(.CNT_W(CNT_W)) u_timer (
        .pclk  (pclk),
        .rst   (rst),
        .clr   (restart),
        .start (tmr_start),
        .pause (pause),
        .limit (tmr_limit),
        .done  (tmr_done)
    );

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            level          <= START_L;
            armed          <= 1'b0;
            level_up_out   <= 1'b0;
            level_up_pulse <= 1'b0;
            respawn        <= 1'b0;
        end else if (restart) begin
            state          <= IDLE;
            level          <= START_L;
            armed          <= 1'b0;
            level_up_out   <= 1'b0;
            level_up_pulse <= 1'b0;
            respawn        <= 1'b0;
        end else begin
            level_up_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    // armed needs a live enemy first, so a late respawn cannot re-trigger.
                    if (lives != '0)
                        armed <= 1'b1;
                    else if (armed)
                        state <= LEVEL_UP;
                end
                LEVEL_UP: begin
                    state          <= HOLD;
                    level          <= next_level;
                    level_up_pulse <= 1'b1;
                    level_up_out   <= 1'b1;
                end
                HOLD: begin
                    if (tmr_done) begin
                        state   <= RELOAD;
                        respawn <= 1'b1;
                    end
                end
                RELOAD: begin
                    if (tmr_done) begin
                        state        <= IDLE;
                        respawn      <= 1'b0;
                        level_up_out <= 1'b0;
                        armed        <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_level_ctrl.sv
// Directed bench for level_ctrl with short HOLD/RELOAD and MAX_LEVEL=3.
module tb_level_ctrl;

    logic       pclk;
    logic       rst;
    logic [4:0] lives;
    logic       restart;
    logic       pause;
    logic [3:0] level;
    logic       level_up_out;
    logic       level_up_pulse;
    logic       respawn;
    logic       game_won;

    int n_assert = 0;
    int n_fail   = 0;

    level_ctrl #(
        .N_ENEMIES     (5),
        .LEVEL_W       (4),
        .START_LEVEL   (1),
        .MAX_LEVEL     (3),
        .HOLD_CYCLES   (10),
        .RELOAD_CYCLES (3)
    ) dut (
        .pclk           (pclk),
        .rst            (rst),
        .lives          (lives),
        .restart        (restart),
        .pause          (pause),
        .level          (level),
        .level_up_out   (level_up_out),
        .level_up_pulse (level_up_pulse),
        .respawn        (respawn),
        .game_won       (game_won)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Hold lives nonzero for n cycles, then drop to 0 (wave cleared).
    task automatic arm(input int n);
        lives = 5'h1F;
        repeat (n) @(negedge pclk);
        lives = 5'h00;
    endtask

    // Observe w cycles; pause is driven high for pl cycles starting after sample ps.
    task automatic window(input int w, input int ps, input int pl,
                          output int lat, output int np, output int nluo,
                          output int nresp, output int rfirst);
        lat = -1; rfirst = -1; np = 0; nluo = 0; nresp = 0;
        for (int i = 1; i <= w; i++) begin
            @(negedge pclk);
            if (level_up_pulse) begin
                np++;
                if (lat < 0) lat = i;
            end
            if (level_up_out) nluo++;
            if (respawn) begin
                nresp++;
                if (rfirst < 0) rfirst = i;
            end
            pause = (i >= ps) && (i < ps + pl);
        end
        pause = 1'b0;
    endtask

    initial begin
        int lat, np, nluo, nresp, rfirst;
        logic ok;

        rst = 1'b1; lives = '0; restart = 1'b0; pause = 1'b0;
        repeat (2) @(negedge pclk);
        rst = 1'b0;
        @(negedge pclk);
        chk("rst_level",  level, 1);
        chk("rst_luo",    level_up_out, 0);
        chk("rst_pulse",  level_up_pulse, 0);
        chk("rst_resp",   respawn, 0);
        chk("rst_won",    game_won, 0);

        // Never armed: lives stays 0
        window(50, 0, 0, lat, np, nluo, nresp, rfirst);
        chk("noarm_pulses", np, 0);
        chk("noarm_resp",   nresp, 0);
        chk("noarm_luo",    nluo, 0);
        chk("noarm_level",  level, 1);

        // Clear wave; the window also covers 25 cycles of late respawn
        arm(2);
        window(40, 0, 0, lat, np, nluo, nresp, rfirst);
        chk("clr_latency", lat, 2);
        chk("clr_pulses",  np, 1);
        chk("clr_luo",     nluo, 13);
        chk("clr_resp",    nresp, 3);
        chk("clr_rfirst",  rfirst, 12);
        chk("clr_level",   level, 2);
        chk("clr_won",     game_won, 0);

        // Pause 7 cycles mid-HOLD
        arm(1);
        window(40, 5, 7, lat, np, nluo, nresp, rfirst);
        chk("pause_pulses", np, 1);
        chk("pause_luo",    nluo, 20);
        chk("pause_resp",   nresp, 3);
        chk("pause_rfirst", rfirst, 19);
        chk("pause_level",  level, 3);
        chk("pause_won",    game_won, 0);

        // Third clear at MAX_LEVEL
        arm(2);
        window(40, 0, 0, lat, np, nluo, nresp, rfirst);
        chk("max_pulses", np, 1);
        chk("max_resp",   nresp, 3);
`ifdef LEVEL_WRAP_EN
        chk("max_level",  level, 1);
        chk("max_won",    game_won, 0);
`else
        chk("max_level",  level, 3);
        chk("max_won",    game_won, 1);
`endif

        // Asynchronous rst mid-HOLD
        arm(1);
        repeat (5) @(negedge pclk);
        chk("arst_in_hold", level_up_out, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_level", level, 1);
        chk("arst_luo",   level_up_out, 0);
        chk("arst_pulse", level_up_pulse, 0);
        chk("arst_resp",  respawn, 0);
        chk("arst_won",   game_won, 0);
        @(negedge pclk);
        rst = 1'b0;
        @(negedge pclk);

        // Synchronous restart in RELOAD
        arm(1);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge pclk);
            if (respawn) ok = 1'b1;
        end
        chk("rstrt_reach_reload", ok, 1);
        chk("rstrt_pre_level", level, 2);
        restart = 1'b1;
        #1;
        chk("rstrt_sync", level, 2);
        @(negedge pclk);
        restart = 1'b0;
        chk("rstrt_level", level, 1);
        chk("rstrt_resp",  respawn, 0);
        chk("rstrt_luo",   level_up_out, 0);
        window(20, 0, 0, lat, np, nluo, nresp, rfirst);
        chk("rstrt_no_pulse", np, 0);
        chk("rstrt_no_resp",  nresp, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
